// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } rxCtrlState_t;

  // One stored frame: {parity flag, data byte}
  localparam int FRAME_W = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; output reads zero while empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receiver handshake sequencer: captures bytes into a FIFO, exposes a valid/ready stream
// and keeps overflow / parity-error statistics.
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     rxReceive,
  input  logic [7:0]               rxDout,
  input  logic                     rxParityErr,
  output logic                     rxReceived,
  output logic [7:0]               outData,
  output logic                     outPerr,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     overflow,
  input  logic                     clrOverflow,
  output logic [ERRCNT_W-1:0]      errCount
);

  rxCtrlState_t         state;
  rxCtrlState_t         state_next;
  logic                 capture;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push_ok;
  logic                 drop;
  logic [FRAME_W-1:0]   fifo_dout;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= WAIT;
      rxReceived <= 1'b0;
    end else begin
      state      <= state_next;
      rxReceived <= (state_next == ACK);
    end
  end

  always_comb begin
    state_next = WAIT;
    capture    = 1'b0;
    case (state)
      WAIT:    state_next = rxReceive ? CAPTURE : WAIT;
      CAPTURE: begin
        state_next = ACK;
        capture    = 1'b1;
      end
      ACK:     state_next = rxReceive ? ACK : WAIT;
      default: state_next = WAIT;
    endcase
  end

  assign fifo_pop = outValid & outReady;
  assign push_ok  = capture & (~fifo_full | fifo_pop);
  assign drop     = capture & fifo_full & ~fifo_pop;

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (Reset_n),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   ({rxParityErr, rxDout}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifoCount)
  );

  assign outValid = ~fifo_empty;
  assign outPerr  = fifo_dout[8];
  assign outData  = fifo_dout[7:0];

  // A drop in the same cycle as a clear wins, so no lost frame goes unreported.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (drop)             overflow <= 1'b1;
      else if (clrOverflow) overflow <= 1'b0;
      if (capture && rxParityErr && (errCount != '1))
        errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: queue-based reference model plus directed and random frames.
module tb_rx_frame_ctrl;

  localparam int DEPTH = 8;
  localparam int EW    = 2;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          rxReceive = 1'b0;
  logic [7:0]    rxDout = 8'h00;
  logic          rxParityErr = 1'b0;
  logic          outReady = 1'b0;
  logic          clrOverflow = 1'b0;
  logic          rxReceived;
  logic [7:0]    outData;
  logic          outPerr;
  logic          outValid;
  logic [3:0]    fifoCount;
  logic          overflow;
  logic [EW-1:0] errCount;

  rx_frame_ctrl #(.DEPTH(DEPTH), .ERRCNT_W(EW)) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .rxReceive   (rxReceive),
    .rxDout      (rxDout),
    .rxParityErr (rxParityErr),
    .rxReceived  (rxReceived),
    .outData     (outData),
    .outPerr     (outPerr),
    .outValid    (outValid),
    .outReady    (outReady),
    .fifoCount   (fifoCount),
    .overflow    (overflow),
    .clrOverflow (clrOverflow),
    .errCount    (errCount)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: occupancy, statistics and handshake phase at transaction level.
  int          mcount = 0;
  int          merr = 0;
  bit          movf = 1'b0;
  bit          in_ack = 1'b0;
  bit          cap_pending = 1'b0;
  logic [8:0]  sb[$];
  bit          rand_ready = 1'b0;
  bit          rand_clr = 1'b0;

  initial begin
    bit pop_m;
    bit drop_m;
    forever begin
      @(posedge clk or negedge Reset_n);
      if (!Reset_n) begin
        mcount = 0; merr = 0; movf = 1'b0; in_ack = 1'b0; cap_pending = 1'b0;
        sb.delete();
      end else begin
        pop_m  = (mcount > 0) && outReady;
        drop_m = 1'b0;
        if (pop_m) mcount--;
        if (cap_pending) begin
          if (rxParityErr && merr < EMAX) merr++;
          if (mcount < DEPTH) begin
            sb.push_back({rxParityErr, rxDout});
            mcount++;
          end else begin
            drop_m = 1'b1;
            movf   = 1'b1;
          end
          cap_pending = 1'b0;
          in_ack      = 1'b1;
        end else if (in_ack) begin
          if (!rxReceive) in_ack = 1'b0;
        end else if (rxReceive) begin
          cap_pending = 1'b1;
        end
        if (clrOverflow && !drop_m) movf = 1'b0;
      end
    end
  end

  // Monitor: status every cycle, data popped from the scoreboard on each accepted transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (Reset_n) begin
        chk("fifoCount", int'(fifoCount), mcount);
        chk("outValid", int'(outValid), int'(mcount > 0));
        chk("overflow", int'(overflow), int'(movf));
        chk("errCount", int'(errCount), merr);
        chk("rxReceived", int'(rxReceived), int'(in_ack));
        if (!outValid) chk("emptyData", int'({outPerr, outData}), 0);
        else if (sb.size() > 0) chk("headData", int'({outPerr, outData}), int'(sb[0]));
        if (outValid && outReady) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL popUnderrun: got pop with data %0d expected no entry", int'({outPerr, outData}));
          end else begin
            chk("popData", int'({outPerr, outData}), int'(sb.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) outReady = 1'($urandom_range(0, 1));
      if (rand_clr) clrOverflow = ($urandom_range(0, 15) == 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; runs one complete Receive/Received handshake.
  task automatic send_frame(input logic [7:0] d, input bit pe, input int hold,
                            input bit pop_cap, input bit rst_ack);
    rxDout = d; rxParityErr = pe; rxReceive = 1'b1;
    @(negedge clk); chk("rxRecvK", int'(rxReceived), 0);
    @(posedge clk); #1; if (pop_cap) outReady = 1'b1;
    @(negedge clk); chk("rxRecvCapture", int'(rxReceived), 0);
    @(posedge clk); #1; if (pop_cap) outReady = 1'b0;
    @(negedge clk); chk("rxRecvRise", int'(rxReceived), 1);
    if (rst_ack) begin
      #2; Reset_n = 1'b0; rxReceive = 1'b0;
      #1;
      chk("rstRxReceived", int'(rxReceived), 0);
      chk("rstFifoCount", int'(fifoCount), 0);
      chk("rstOverflow", int'(overflow), 0);
      chk("rstOutValid", int'(outValid), 0);
      @(posedge clk); #1; Reset_n = 1'b1;
      return;
    end
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    rxReceive = 1'b0;
    @(negedge clk); chk("rxRecvHold", int'(rxReceived), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rxRecvFall", int'(rxReceived), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b;
    #12;
    chk("resetRxReceived", int'(rxReceived), 0);
    chk("resetOutValid", int'(outValid), 0);
    chk("resetFifoCount", int'(fifoCount), 0);
    chk("resetOutData", int'({outPerr, outData}), 0);
    chk("resetOverflow", int'(overflow), 0);
    chk("resetErrCount", int'(errCount), 0);
    @(posedge clk); #1; Reset_n = 1'b1;
    cyc(2);

    outReady = 1'b1;
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    cyc(2);
    chk("singleErrCount", int'(errCount), 0);
    send_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0);
    cyc(2);
    chk("heldOnePushDrained", int'(fifoCount), 0);

    outReady = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 0, 1'b0, 1'b0);
    chk("fullCount", int'(fifoCount), DEPTH);
    chk("overflowSet", int'(overflow), 1);
    clrOverflow = 1'b1; cyc(1); clrOverflow = 1'b0;
    chk("overflowClr", int'(overflow), 0);

    send_frame(8'h55, 1'b0, 0, 1'b1, 1'b0);
    chk("pushPopFullCount", int'(fifoCount), DEPTH);
    chk("pushPopNoOverflow", int'(overflow), 0);
    outReady = 1'b1;
    cyc(12);

    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0);
      chk("errCountSeq", int'(errCount), (i < EMAX) ? i + 1 : EMAX);
    end
    cyc(2);

    outReady = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i), 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'hEE, 1'b0, 0, 1'b0, 1'b1);
    chk("postResetErrCount", int'(errCount), 0);
    cyc(2);

    rand_ready = 1'b1; rand_clr = 1'b1;
    repeat (150) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 1'b0);
      cyc($urandom_range(0, 3));
    end
    rand_ready = 1'b0; rand_clr = 1'b0;
    cyc(1);
    outReady = 1'b1; clrOverflow = 1'b0;
    b = 0;
    while (fifoCount != 0 && b < 50) begin cyc(1); b++; end
    chk("drainDone", int'(fifoCount), 0);
    cyc(2);
    chk("scoreboardEmpty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
